// File: rtl/game_input_pkg.sv
// Shared constants, mode enum and note encoding for the player-input front end.
package game_input_pkg;

    localparam int          NUM_KEYS   = 8;
    localparam int          SONG_SLOTS = 8;
    localparam logic [3:0]  NOTE_REST  = 4'd0;

    typedef enum logic {
        PLAY = 1'b0,
        LOAD = 1'b1
    } mode_e;

    // Key index i plays note i+1; code 0 stays reserved for "no note".
    function automatic logic [3:0] key_to_code(input int idx);
        return 4'(idx + 1);
    endfunction

endpackage

// File: rtl/game_input_encoder_debouncer.sv
// One button lane: 2-FF synchronizer, stability counter and a registered
// press pulse on each accepted 0->1 change of the stable level.
module key_debouncer #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [1:0]    sync;
    logic          stable;
    logic [CW-1:0] cnt;
    logic          diff;

    assign diff = sync[1] ^ stable;

    // Synchronize, count consecutive disagreeing cycles, flip the stable level
    // once the count has reached the limit; a press pulse marks a rising flip.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync   <= '0;
            stable <= 1'b0;
            cnt    <= '0;
            press  <= 1'b0;
        end else begin
            sync  <= {sync[0], raw};
            press <= 1'b0;
            if (!diff) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES)) begin
                stable <= sync[1];
                cnt    <= '0;
                press  <= sync[1];
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/game_input_encoder.sv
// Player-input encoder: debounced note keys become answer strobes in play
// mode, or are packed eight at a time into song words in load mode.
module game_input_encoder
    import game_input_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] keys_raw,
    input  logic                clear_raw,
    input  logic                load_mode,
    output logic [3:0]          answer,
    output logic                answer_enable,
    output logic [31:0]         data_out,
    output logic                write_enable,
    output logic [3:0]          slot_count,
    output logic                load_busy
);

    localparam int SW = $clog2(SONG_SLOTS);
    localparam int WW = SONG_SLOTS * 4;

    logic [NUM_KEYS:0]  raw_all;
    logic [NUM_KEYS:0]  ev;
    logic               clear_ev;
    logic               key_hit;
    logic [3:0]         key_code;
    logic [WW-1:0]      shadow;
    logic [WW-1:0]      commit_word;
    logic [3:0]         slot_base;
    mode_e              state, next_state;
    logic               do_answer, do_slot, do_commit, do_flush;

    // Clear rides as the top lane so all buttons share one debouncer array.
    assign raw_all  = {clear_raw, keys_raw};
    assign clear_ev = ev[NUM_KEYS];

    generate
        for (genvar g = 0; g <= NUM_KEYS; g++) begin : g_deb
            key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
                .clk   (clk),
                .reset (reset),
                .raw   (raw_all[g]),
                .press (ev[g])
            );
        end
    endgenerate

    // Lowest key index wins among coincident presses; the rest are dropped.
    always_comb begin
        key_hit  = 1'b0;
        key_code = NOTE_REST;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (ev[i]) begin
                key_hit  = 1'b1;
                key_code = key_to_code(i);
            end
        end
    end

    // Mode register, tracks load_mode one cycle behind.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= PLAY;
        else       state <= next_state;
    end

    // The mode in effect this cycle is the one sampled now, so an event that
    // coincides with a mode change obeys the new mode.
    always_comb begin
        next_state = load_mode ? LOAD : PLAY;
    end

    // Entry into LOAD always begins at slot 0; otherwise continue the entry.
    assign slot_base = (state == PLAY) ? 4'd0 : slot_count;

    // Action decode for the mode in effect; clear outranks a key press.
    always_comb begin
        do_answer = 1'b0;
        do_slot   = 1'b0;
        do_commit = 1'b0;
        do_flush  = 1'b0;
        case (next_state)
            PLAY: begin
                do_answer = key_hit;
                do_flush  = 1'b1;
            end
            LOAD: begin
                if (clear_ev)
                    do_flush = 1'b1;
                else if (key_hit && slot_base == 4'(SONG_SLOTS - 1))
                    do_commit = 1'b1;
                else if (key_hit)
                    do_slot = 1'b1;
            end
            default: do_flush = 1'b1;
        endcase
    end

    // Full word includes the nibble arriving with the final press.
    always_comb begin
        commit_word = shadow;
        commit_word[(SONG_SLOTS - 1) * 4 +: 4] = key_code;
    end

    // Registered outputs, strobes and the packing shadow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            answer        <= 4'd0;
            answer_enable <= 1'b0;
            data_out      <= '0;
            write_enable  <= 1'b0;
            slot_count    <= 4'd0;
            shadow        <= '0;
        end else begin
            answer_enable <= 1'b0;
            write_enable  <= 1'b0;
            if (do_answer) begin
                answer        <= key_code;
                answer_enable <= 1'b1;
            end
            if (do_flush) begin
                slot_count <= 4'd0;
                shadow     <= '0;
            end else if (do_commit) begin
                data_out     <= commit_word;
                write_enable <= 1'b1;
                slot_count   <= 4'd0;
                shadow       <= '0;
            end else if (do_slot) begin
                shadow[{slot_base[SW-1:0], 2'b00} +: 4] <= key_code;
                slot_count <= slot_base + 4'd1;
            end
        end
    end

    assign load_busy = (slot_count != 4'd0);

endmodule

// File: tb/tb_game_input_encoder.sv
// Directed and randomized bench for game_input_encoder with a transaction-level
// model: presses become notes, notes become answers or packed song words.
module tb_game_input_encoder;
    import game_input_pkg::*;

    localparam int D    = 4;
    localparam int HOLD = D + 6;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic [NUM_KEYS-1:0] keys_raw = '0;
    logic                clear_raw = 1'b0;
    logic                load_mode = 1'b0;
    logic [3:0]          answer;
    logic                answer_enable;
    logic [31:0]         data_out;
    logic                write_enable;
    logic [3:0]          slot_count;
    logic                load_busy;

    game_input_encoder #(.DEBOUNCE_CYCLES(D)) dut (
        .clk           (clk),
        .reset         (reset),
        .keys_raw      (keys_raw),
        .clear_raw     (clear_raw),
        .load_mode     (load_mode),
        .answer        (answer),
        .answer_enable (answer_enable),
        .data_out      (data_out),
        .write_enable  (write_enable),
        .slot_count    (slot_count),
        .load_busy     (load_busy)
    );

    always #5 clk = ~clk;

    int vectors = 0, miscompares = 0;
    int ae_cnt = 0, we_cnt = 0, both_cnt = 0;

    // Strobe counters sampled shortly after each rising edge.
    always @(posedge clk) begin
        #2;
        if (answer_enable) ae_cnt++;
        if (write_enable) we_cnt++;
        if (answer_enable && write_enable) both_cnt++;
    end

    // Reference model state.
    logic        mode_m = 1'b0;
    logic [3:0]  q[$];
    int          exp_ae = 0, exp_we = 0;
    logic [3:0]  exp_ans = 4'd0;
    logic [31:0] exp_data = 32'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Model: one accepted press of key k (k == NUM_KEYS means clear).
    task automatic model_event(input int k);
        logic [31:0] w;
        if (k == NUM_KEYS) begin
            if (mode_m) q.delete();
        end else if (!mode_m) begin
            exp_ae++;
            exp_ans = 4'(k + 1);
        end else begin
            q.push_back(4'(k + 1));
            if (q.size() == SONG_SLOTS) begin
                w = 32'd0;
                for (int s = 0; s < SONG_SLOTS; s++) w = w + (32'(q[s]) << (4 * s));
                exp_data = w;
                exp_we++;
                q.delete();
            end
        end
    endtask

    task automatic drive(input int k, input logic v);
        if (k == NUM_KEYS) clear_raw = v;
        else keys_raw[k] = v;
    endtask

    task automatic press(input int k);
        drive(k, 1'b1);
        cyc(HOLD);
        drive(k, 1'b0);
        cyc(HOLD);
        model_event(k);
    endtask

    task automatic press2(input int a, input int b);
        drive(a, 1'b1);
        drive(b, 1'b1);
        cyc(HOLD);
        drive(a, 1'b0);
        drive(b, 1'b0);
        cyc(HOLD);
        model_event(a < b ? a : b);
    endtask

    task automatic glitch(input int k, input int len);
        drive(k, 1'b1);
        cyc(len);
        drive(k, 1'b0);
        cyc(HOLD);
    endtask

    task automatic set_mode(input logic m);
        load_mode = m;
        cyc(2);
        mode_m = m;
        if (!m) q.delete();
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".answer"}, 32'(answer), 32'(exp_ans));
        chk({tag, ".ae_cnt"}, 32'(ae_cnt), 32'(exp_ae));
        chk({tag, ".data_out"}, data_out, exp_data);
        chk({tag, ".we_cnt"}, 32'(we_cnt), 32'(exp_we));
        chk({tag, ".slot_count"}, 32'(slot_count), 32'(q.size()));
        chk({tag, ".load_busy"}, 32'(load_busy), 32'(q.size() != 0));
    endtask

    initial begin
        int first_at;
        int k, a, b;

        // Reset state
        cyc(3);
        chk("rst.answer_enable", 32'(answer_enable), 32'd0);
        chk("rst.write_enable", 32'(write_enable), 32'd0);
        reset = 1'b0;
        cyc(2);
        check_all("rst");

        // Bouncing key never settles long enough
        for (int i = 0; i < 15; i++) begin
            keys_raw[5] = ~keys_raw[5];
            cyc(2);
        end
        keys_raw[5] = 1'b0;
        cyc(HOLD);
        check_all("glitch");

        // Exact latency: pulse seen after edge N+D+3
        keys_raw[2] = 1'b1;
        first_at = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (answer_enable && first_at < 0) first_at = i;
        end
        chk("latency", 32'(first_at), 32'(D + 4));
        keys_raw[2] = 1'b0;
        cyc(15);
        model_event(2);
        check_all("play_k2");

        // Ordered load of all keys
        set_mode(1'b1);
        for (int i = 0; i < NUM_KEYS; i++) begin
            press(i);
            check_all("load_seq");
        end
        chk("load_seq.word", data_out, 32'h87654321);

        // Clear mid-entry, then a full entry of key 0
        press(7); press(7); press(7);
        check_all("pre_clear");
        press(NUM_KEYS);
        check_all("clear");
        for (int i = 0; i < 8; i++) press(0);
        check_all("ones");
        chk("ones.word", data_out, 32'h11111111);

        // Leaving LOAD discards a partial entry
        press(3); press(3); press(3);
        set_mode(1'b0);
        check_all("abandon");
        set_mode(1'b1);
        for (int i = 0; i < 7; i++) press(1);
        check_all("twos_partial");
        press(1);
        check_all("twos");
        chk("twos.word", data_out, 32'h22222222);

        // Simultaneous presses in PLAY
        set_mode(1'b0);
        press2(1, 4);
        check_all("simul");
        chk("simul.answer", 32'(answer), 32'd2);

        // Clear in PLAY is ignored
        press(NUM_KEYS);
        check_all("play_clear");

        // Randomized operation mix
        for (int n = 0; n < 80; n++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5: begin
                    k = $urandom_range(0, NUM_KEYS - 1);
                    press(k);
                end
                6: glitch($urandom_range(0, NUM_KEYS), $urandom_range(1, D - 1));
                7: press(NUM_KEYS);
                8: set_mode(~mode_m);
                default: begin
                    a = $urandom_range(0, NUM_KEYS - 1);
                    b = (a + $urandom_range(1, NUM_KEYS - 1)) % NUM_KEYS;
                    press2(a, b);
                end
            endcase
            check_all("rand");
        end

        // Reset mid-entry and mid-debounce discards everything
        set_mode(1'b1);
        press(0); press(1); press(2);
        keys_raw[3] = 1'b1;
        cyc(3);
        reset = 1'b1;
        keys_raw[3] = 1'b0;
        cyc(2);
        q.delete();
        exp_ans = 4'd0;
        exp_data = 32'd0;
        check_all("mid_reset");
        reset = 1'b0;
        cyc(20);
        check_all("post_reset");

        chk("never_both", 32'(both_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
